// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Bytes per instruction word.
  function automatic int bpw(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian word from a byte stream and flags full or
// partial (last-byte) completion.
module byte_packer
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  input  logic                  last,
  output logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] partial,
  output logic                  word_valid,
  output logic                  flush_req
);

  localparam int BPW    = bpw(DATA_WIDTH);
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

  logic [LANE_W-1:0]     lane;
  logic [DATA_WIDTH-1:0] acc;

  // Current byte merged into the lanes gathered so far; upper lanes stay zero.
  always_comb begin
    word = acc;
    word[lane*8 +: 8] = data;
  end

  assign partial    = acc;
  assign word_valid = accept && (lane == LAST_LANE);
  assign flush_req  = accept && last && (lane != LAST_LANE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
      acc  <= '0;
    end else if (clear) begin
      lane <= '0;
      acc  <= '0;
    end else if (accept) begin
      if (lane == LAST_LANE) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
        acc  <= word;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a registered fetch port and a byte-serial
// program-load port; fetches are refused while a load is in progress.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_LOG2    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] A,
  input  logic                     fetch_en,
  output logic [DATA_WIDTH-1:0]    RD,
  output logic                     rd_valid,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_done,
  output logic                     load_err,
  output logic                     busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_PTR = {1'b1, {DEPTH_LOG2{1'b0}}};

  imem_state_t state, next_state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2:0]   ptr;
  logic                  accept, start, ptr_full, wr_en;
  logic                  word_valid, flush_req, pack_clear;
  logic                  fetch_ok, addr_bad;
  logic [DATA_WIDTH-1:0] word, partial, wr_data;
  logic [DEPTH_LOG2-1:0] rd_idx;

  assign load_ready = (state == LOAD);
  assign busy       = (state == LOAD);
  assign accept     = load_valid && load_ready;
  assign start      = load_start && (state == IDLE);
  assign ptr_full   = (ptr == FULL_PTR);
  assign pack_clear = start || (state == FLUSH);
  // The pointer parks at DEPTH on overflow, so excess words are dropped.
  assign wr_en      = !ptr_full && (word_valid || (state == FLUSH));
  assign wr_data    = (state == FLUSH) ? partial : word;
  assign fetch_ok   = fetch_en && (state == IDLE);
  assign addr_bad   = (A[1:0] != 2'b00) || ((A >> (DEPTH_LOG2 + 2)) != '0);
  assign rd_idx     = A[DEPTH_LOG2+1:2];

  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .accept     (accept),
    .data       (load_byte),
    .last       (load_last),
    .word       (word),
    .partial    (partial),
    .word_valid (word_valid),
    .flush_req  (flush_req)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? LOAD : IDLE;
      LOAD:    next_state = flush_req ? FLUSH : ((accept && load_last) ? IDLE : LOAD);
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      load_err  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= next_state;
      load_done <= (state != IDLE) && (next_state == IDLE);
      if (start) begin
        ptr      <= '0;
        load_err <= 1'b0;
      end else begin
        if (wr_en) ptr <= ptr + (DEPTH_LOG2 + 1)'(1);
        if (accept && ptr_full) load_err <= 1'b1;
      end
    end
  end

  // Array carries no reset so a program survives a reset of the loader.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RD       <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= fetch_ok;
      if (fetch_ok) RD <= addr_bad ? '0 : mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench: two loaders (256 and 4 words) share one stimulus stream and are
// checked against an image-level memory model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic        fetch_en = 1'b0, load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [7:0]  load_byte = '0;

  logic [31:0] rd8, rd2;
  logic        rdv8, rdv2, ready8, ready2, done8, done2, err8, err2, busy8, busy2;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m8 [256];
  bit          k8 [256];
  logic [31:0] m2 [4];
  bit          k2 [4];

  always #5 clk = ~clk;

  imem_loader #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(8)) dut8 (
    .clk(clk), .rst(rst), .A(a), .fetch_en(fetch_en), .RD(rd8), .rd_valid(rdv8),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(ready8), .load_done(done8),
    .load_err(err8), .busy(busy8));

  imem_loader #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .A(a), .fetch_en(fetch_en), .RD(rd2), .rd_valid(rdv2),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(ready2), .load_done(done2),
    .load_err(err2), .busy(busy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Words of an image, little-endian, last word zero-padded; full_only keeps
  // only complete words (what survives a reset mid-load).
  task automatic model_apply(input logic [7:0] img[$], input bit full_only);
    for (int w = 0; w * 4 < img.size(); w++) begin
      logic [31:0] wd;
      int nb;
      wd = '0;
      nb = 0;
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < img.size()) begin
          wd[8*b +: 8] = img[w*4+b];
          nb++;
        end
      end
      if (!full_only || nb == 4) begin
        if (w < 256) begin m8[w] = wd; k8[w] = 1'b1; end
        if (w < 4)   begin m2[w] = wd; k2[w] = 1'b1; end
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input int dl, input logic [31:0] addr, output bit known);
    int idx;
    known = 1'b1;
    exp_rd = '0;
    if (addr[1:0] == 2'b00 && (addr >> (dl + 2)) == 32'd0) begin
      idx = int'(addr >> 2);
      if (dl == 8) begin known = k8[idx]; exp_rd = m8[idx]; end
      else         begin known = k2[idx]; exp_rd = m2[idx]; end
    end
  endfunction

  task automatic fetch(input logic [31:0] addr);
    logic [31:0] e8, e2;
    bit kn8, kn2;
    e8 = exp_rd(8, addr, kn8);
    e2 = exp_rd(2, addr, kn2);
    fetch_en = 1'b1;
    a = addr;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("fetch_valid8", 32'(rdv8), 32'd1);
    chk("fetch_valid2", 32'(rdv2), 32'd1);
    if (kn8) chk("fetch_rd8", rd8, e8);
    if (kn2) chk("fetch_rd2", rd2, e2);
    @(negedge clk);
    chk("nofetch_valid8", 32'(rdv8), 32'd0);
    if (kn8) chk("nofetch_hold8", rd8, e8);
  endtask

  task automatic load_image(input logic [7:0] img[$], input bit mid_fetch, input bit mid_start);
    int n, acc, cyc, dn8, dn2;
    logic [31:0] hold8, e;
    bit kn;
    n = img.size(); acc = 0; cyc = 0; dn8 = 0; dn2 = 0;
    e = exp_rd(8, 32'd0, kn);
    load_start = 1'b1;
    fetch_en = 1'b1;
    a = '0;
    @(negedge clk);
    load_start = 1'b0;
    fetch_en = 1'b0;
    chk("start_fetch_valid", 32'(rdv8), 32'd1);
    if (kn) chk("start_fetch_rd", rd8, e);
    chk("start_busy8", 32'(busy8), 32'd1);
    chk("start_busy2", 32'(busy2), 32'd1);
    chk("start_err_clear", 32'(err2), 32'd0);
    hold8 = rd8;
    while (acc < n && cyc < 1000) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_byte  = img[acc];
      load_last  = (acc == n - 1);
      fetch_en   = mid_fetch;
      load_start = mid_start && (cyc == 3);
      @(negedge clk);
      if (load_valid) acc++;
      cyc++;
      dn8 += int'(done8);
      dn2 += int'(done2);
      if (acc < n) chk("ready8", 32'(ready8), 32'd1);
      chk("err2", 32'(err2), (acc > 16) ? 32'd1 : 32'd0);
      chk("err8", 32'(err8), 32'd0);
      if (mid_fetch) begin
        chk("busy_fetch_valid", 32'(rdv8), 32'd0);
        chk("busy_fetch_hold", rd8, hold8);
      end
    end
    load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0; load_start = 1'b0;
    if (acc < n) chk("load_timeout", 32'(acc), 32'(n));
    if (n % 4 != 0) begin
      chk("flush_no_done", 32'(done8), 32'd0);
      chk("flush_not_ready", 32'(ready8), 32'd0);
      @(negedge clk);
      dn8 += int'(done8);
      dn2 += int'(done2);
    end
    chk("done8", 32'(done8), 32'd1);
    chk("done2", 32'(done2), 32'd1);
    chk("idle_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    dn8 += int'(done8);
    dn2 += int'(done2);
    chk("done_once8", 32'(dn8), 32'd1);
    chk("done_once2", 32'(dn2), 32'd1);
    model_apply(img, 1'b0);
  endtask

  initial begin
    logic [7:0] q[$];
    for (int i = 0; i < 256; i++) k8[i] = 1'b0;
    for (int i = 0; i < 4; i++) k2[i] = 1'b0;

    #3;
    chk("rst_rd", rd8, 32'd0);
    chk("rst_valid", 32'(rdv8), 32'd0);
    chk("rst_ready", 32'(ready8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_err", 32'(err8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    q = '{8'h13, 8'h03, 8'hF0, 8'h0F, 8'h13, 8'h05, 8'h00, 8'h00};
    load_image(q, 1'b0, 1'b0);
    fetch(32'h0);
    chk("t1_word0", rd8, 32'h0FF00313);
    fetch(32'h4);
    chk("t1_word1", rd8, 32'h00000513);

    q = '{8'h93, 8'h05, 8'h00, 8'h00, 8'hAA};
    load_image(q, 1'b0, 1'b0);
    fetch(32'h4);
    chk("t2_word1", rd8, 32'h000000AA);

    fetch(32'h00000002);
    fetch(32'h00001000);

    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
    load_image(q, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) fetch(32'(i * 4));

    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    load_image(q, 1'b0, 1'b0);
    chk("ovf_err_sticky", 32'(err2), 32'd1);
    for (int i = 0; i < 5; i++) fetch(32'(i * 4));

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 20);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      load_image(q, 1'b0, 1'b0);
      for (int f = 0; f < 6; f++) begin
        logic [31:0] ad;
        ad = 32'($urandom_range(0, 5) * 4);
        if ($urandom_range(0, 7) == 0) ad = ad | 32'd1;
        if ($urandom_range(0, 7) == 0) ad = ad | 32'h0000_0400;
        fetch(ad);
      end
    end

    q = '{8'h13, 8'h03, 8'hF0, 8'h0F, 8'hAA, 8'hBB};
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_byte  = q[i];
      @(negedge clk);
    end
    load_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_rd", rd8, 32'd0);
    chk("arst_valid", 32'(rdv8), 32'd0);
    chk("arst_ready", 32'(ready8), 32'd0);
    chk("arst_done", 32'(done8), 32'd0);
    chk("arst_err", 32'(err2), 32'd0);
    chk("arst_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_no_done", 32'(done8), 32'd0);
    model_apply(q, 1'b1);
    fetch(32'h0);
    fetch(32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
